// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcode, FSM state and result-width definitions for the ALU operation sequencer.
// Used by alu_op_sequencer, its interface and the settle counter.
package alu_pkg;

    localparam int unsigned RESULT_W = 16;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_ADD = 4'h0;
    localparam opcode_t OP_SUB = 4'h1;
    localparam opcode_t OP_MUL = 4'h2;
    localparam opcode_t OP_AND = 4'h3;
    localparam opcode_t OP_OR  = 4'h4;
    localparam opcode_t OP_XOR = 4'h5;
    localparam opcode_t OP_NOT = 4'h6;
    localparam opcode_t OP_SHL = 4'h7;
    localparam opcode_t OP_SHR = 4'h8;
    localparam opcode_t OP_ROL = 4'h9;
    localparam opcode_t OP_ROR = 4'hA;
    localparam opcode_t OP_INC = 4'hB;
    localparam opcode_t OP_DEC = 4'hC;
    localparam opcode_t OP_DIV = 4'hD;
    localparam opcode_t OP_EQ  = 4'hE;
    localparam opcode_t OP_NOP = 4'hF;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_IDLE   = 2'b00;
    localparam seq_state_t ST_SETTLE = 2'b01;
    localparam seq_state_t ST_RESP   = 2'b10;

    function automatic logic is_div_by_zero(input opcode_t op, input logic [7:0] divisor);
        return (op == OP_DIV) && (divisor == 8'h00);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU and response signals of the sequencer bundled as one interface.
// RspErr exists only when ALU_SEQ_DIVZERO_CHECK_EN is defined.
interface alu_op_sequencer_if;
    import alu_pkg::*;

    logic                CmdValid;
    logic                CmdReady;
    logic [7:0]          CmdA;
    logic [7:0]          CmdB;
    opcode_t             CmdOp;
    logic [7:0]          A;
    logic [7:0]          B;
    opcode_t             ALUControl;
    logic [RESULT_W-1:0] ALUResult;
    logic                RspValid;
    logic                RspReady;
    logic [RESULT_W-1:0] RspData;
    opcode_t             RspOp;
    logic [15:0]         OpCount;
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    logic                RspErr;
`endif

    // Environment side: issues commands, hosts the ALU, consumes responses
    modport master (
        output CmdValid, CmdA, CmdB, CmdOp, ALUResult, RspReady,
        input  CmdReady, A, B, ALUControl, RspValid, RspData, RspOp, OpCount
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
        , input RspErr
`endif
    );

    // Sequencer side
    modport slave (
        input  CmdValid, CmdA, CmdB, CmdOp, ALUResult, RspReady,
        output CmdReady, A, B, ALUControl, RspValid, RspData, RspOp, OpCount
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
        , output RspErr
`endif
    );

endinterface

// File: rtl/alu_op_sequencer_settle_counter.sv
// Loadable 4-bit down-counter with zero flag; paces the ALU settle window.
module alu_settle_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count_r;

    // Load has priority over decrement; the count saturates at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 4'd0;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != 4'd0)) begin
            count_r <= count_r - 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == 4'd0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one command at a time through an external combinational ALU8bit.
// Optional macro ALU_SEQ_DIVZERO_CHECK_EN short-circuits divide-by-zero with RspErr.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1   // legal 1..15
) (
    input logic               clk,
    input logic               rst_n,
    alu_op_sequencer_if.slave sif
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    seq_state_t          state_r;
    logic [7:0]          a_r;
    logic [7:0]          b_r;
    opcode_t             ctrl_r;
    logic                cmd_ready_r;
    logic                rsp_valid_r;
    logic [RESULT_W-1:0] rsp_data_r;
    opcode_t             rsp_op_r;
    logic [15:0]         op_count_r;

    logic accept_s;
    logic divzero_s;
    logic cnt_load_s;
    logic cnt_dec_s;
    logic cnt_zero_s;

    assign accept_s   = (state_r == ST_IDLE) && sif.CmdValid;
    assign cnt_load_s = accept_s && !divzero_s;
    assign cnt_dec_s  = (state_r == ST_SETTLE);

`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    logic rsp_err_r;

    assign divzero_s  = is_div_by_zero(sif.CmdOp, sif.CmdB);
    assign sif.RspErr = rsp_err_r;

    // Error flag describes the response produced by the most recent accepted command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_r <= 1'b0;
        end else if (accept_s) begin
            rsp_err_r <= divzero_s;
        end else begin
            rsp_err_r <= rsp_err_r;
        end
    end
`else
    assign divzero_s = 1'b0;
`endif

    alu_settle_counter u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load_s),
        .load_val (SETTLE_LOAD),
        .dec      (cnt_dec_s),
        .zero     (cnt_zero_s)
    );

    // Main sequencer: accept, wait for the ALU to settle, hold the response until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            a_r         <= 8'h00;
            b_r         <= 8'h00;
            ctrl_r      <= OP_NOP;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 16'h0000;
            rsp_op_r    <= OP_NOP;
            op_count_r  <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sif.CmdValid) begin
                        cmd_ready_r <= 1'b0;
                        if (divzero_s) begin
                            // Never present a zero divisor to the ALU; answer immediately
                            ctrl_r      <= OP_NOP;
                            rsp_data_r  <= 16'hFFFF;
                            rsp_op_r    <= OP_DIV;
                            rsp_valid_r <= 1'b1;
                            state_r     <= ST_RESP;
                        end else begin
                            a_r     <= sif.CmdA;
                            b_r     <= sif.CmdB;
                            ctrl_r  <= sif.CmdOp;
                            state_r <= ST_SETTLE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_zero_s) begin
                        rsp_data_r  <= sif.ALUResult;
                        rsp_op_r    <= ctrl_r;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        state_r <= ST_SETTLE;
                    end
                end
                ST_RESP: begin
                    if (sif.RspReady) begin
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        op_count_r  <= op_count_r + 16'd1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign sif.CmdReady   = cmd_ready_r;
    assign sif.A          = a_r;
    assign sif.B          = b_r;
    assign sif.ALUControl = ctrl_r;
    assign sif.RspValid   = rsp_valid_r;
    assign sif.RspData    = rsp_data_r;
    assign sif.RspOp      = rsp_op_r;
    assign sif.OpCount    = op_count_r;

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 1, clock edges between driving ALU operands and sampling ALUResult; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 CmdValid  input  1  command present.
REQ-005 CmdReady  output  1  sequencer accepts a command this cycle.
REQ-006 CmdA, CmdB  input  8 each  command operands.
REQ-007 CmdOp  input  4  ALU opcode (0000 add .. 1101 div, 1110 equal, 1111 NOP).
REQ-008 A, B  output  8 each  registered operands driven to ALU8bit.
REQ-009 ALUControl  output  4  registered opcode driven to ALU8bit.
REQ-010 ALUResult  input  16  combinational ALU8bit result.
REQ-011 RspValid  output  1  response present.
REQ-012 RspReady  input  1  consumer takes response.
REQ-013 RspData  output  16  captured result; RspOp  output  4  opcode of that result.
REQ-014 OpCount  output  16  completed-response counter.

Function
REQ-015 FSM states IDLE, SETTLE, RESP; CmdReady SHALL be 1 only in IDLE.
REQ-016 IDLE: CmdValid=1 at an edge -> register CmdA/CmdB/CmdOp into A/B/ALUControl, load settle counter with SETTLE_CYCLES-1, go to SETTLE.
REQ-017 SETTLE: counter decrements each edge; at the edge where counter is 0, capture ALUResult into RspData and ALUControl into RspOp, go to RESP.
REQ-018 Latency: RspValid SHALL rise exactly SETTLE_CYCLES edges after the accepting edge.
REQ-019 RESP: RspValid=1; RspData/RspOp held stable until RspValid&&RspReady at an edge, then return to IDLE.
REQ-020 Throughput: next command accepted no earlier than the cycle after the response handshake; no command overlap.
REQ-021 A/B/ALUControl SHALL hold their values through SETTLE and RESP and change only on command acceptance.
REQ-022 Command while not in IDLE is ignored (CmdReady=0); CmdValid low in IDLE keeps IDLE.
REQ-023 OpCount increments by 1 on each response handshake; wraps 0xFFFF -> 0x0000.
REQ-024 NOP (1111) commands are sequenced like any other opcode and counted.

Reset
REQ-025 rst_n low: state IDLE, A=B=0, ALUControl=1111, RspValid=0, RspData=0, RspOp=1111, OpCount=0, counter=0; RspErr=0 when present.
REQ-026 Reset in SETTLE or RESP discards the in-flight operation; no response after release.
REQ-027 CmdReady SHALL be 1 on the first cycle after rst_n deasserts.

Configuration
REQ-028 Macro ALU_SEQ_DIVZERO_CHECK_EN: when defined, add output RspErr (1 bit); a command with CmdOp=1101 and CmdB=0 goes IDLE -> RESP directly, ALUControl stays 1111, RspData=0xFFFF, RspOp=1101, RspErr=1; RspErr=0 for all other responses.
REQ-029 When undefined: no RspErr port; divide-by-zero is forwarded to the ALU and its result returned unchanged with normal latency.

Structure
REQ-030 Shared package alu_pkg: 4-bit opcode constants (OP_ADD .. OP_NOP), FSM state typedef, result width constant 16.
REQ-031 Sub-module alu_settle_counter (loadable 4-bit down-counter with zero flag); ALU8bit is instantiated outside this block.

Verification
REQ-032 SETTLE_CYCLES=1, CmdA=0xF1, CmdB=0x01, CmdOp=0000 -> A=0xF1 after accept edge, RspValid one edge later, RspData=0x00F2, RspOp=0000.
REQ-033 SETTLE_CYCLES=3, mul 0x02*0x01 -> RspValid exactly 3 edges after accept, RspData=0x0002.
REQ-034 RspReady held low 5 cycles in RESP -> RspData/RspOp stable, CmdReady=0, new CmdValid ignored; handshake -> IDLE, OpCount+1.
REQ-035 Macro defined, CmdOp=1101, CmdB=0 -> RspValid on next edge, RspData=0xFFFF, RspErr=1, ALUControl remains 1111.
REQ-036 rst_n pulsed low during SETTLE -> all outputs at reset values immediately, no RspValid afterwards, CmdReady=1 after release.
REQ-037 Preload 65535 completed ops (or force) -> next handshake wraps OpCount to 0x0000.
